// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-master PicoRV32 memory bus arbiter.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// PicoRV32 native memory bus bundle; master drives the request, slave answers.
interface mem_bus_arbiter_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-request round-robin pick: on a tie the master not granted last wins.
module rr_arb2
    import mem_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // last_grant = 1 means master 1 owned the previous transaction
    always_comb begin
        grant = GNT_NONE;
        case (req)
            2'b01:   grant = GNT_M0;
            2'b10:   grant = GNT_M1;
            2'b11:   grant = last_grant ? GNT_M0 : GNT_M1;
            default: grant = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master to one-slave arbiter with registered request capture, round-robin
// arbitration, grant held until slave completion, and a per-transaction timeout.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    mem_bus_arbiter_if.slave         m0,
    mem_bus_arbiter_if.slave         m1,
    mem_bus_arbiter_if.master        s,
    output logic [1:0]               grant,
    output logic                     timeout_err
);

    localparam int            CW        = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit            TO_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_PRE   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT   = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};

    state_t        state, state_n;
    logic          last_grant, last_grant_n;
    logic [1:0]    grant_n, pick;
    logic          req_valid, req_valid_n;
    logic [31:0]   req_addr, req_addr_n, req_wdata, req_wdata_n;
    logic [3:0]    req_wstrb, req_wstrb_n;
    logic [1:0]    ready, ready_n;
    logic [31:0]   rdata0, rdata0_n, rdata1, rdata1_n;
    logic          terr_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          resp_fire;
    logic [31:0]   resp_data;

    rr_arb2 u_arb (
        .req        ({m1.mem_valid, m0.mem_valid}),
        .last_grant (last_grant),
        .grant      (pick)
    );

    // Next-state and next-output logic; response outputs default to a cleared pulse
    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        grant_n      = grant;
        req_valid_n  = req_valid;
        req_addr_n   = req_addr;
        req_wdata_n  = req_wdata;
        req_wstrb_n  = req_wstrb;
        ready_n      = 2'b00;
        rdata0_n     = 32'h0000_0000;
        rdata1_n     = 32'h0000_0000;
        terr_n       = 1'b0;
        cnt_n        = cnt;
        resp_fire    = 1'b0;
        resp_data    = 32'h0000_0000;

        case (state)
            ST_IDLE: begin
                cnt_n = CNT_ZERO;
                if (pick != GNT_NONE) begin
                    grant_n     = pick;
                    req_valid_n = 1'b1;
                    state_n     = ST_BUSY;
                    if (pick == GNT_M1) begin
                        req_addr_n  = m1.mem_addr;
                        req_wdata_n = m1.mem_wdata;
                        req_wstrb_n = m1.mem_wstrb;
                    end else begin
                        req_addr_n  = m0.mem_addr;
                        req_wdata_n = m0.mem_wdata;
                        req_wstrb_n = m0.mem_wstrb;
                    end
                end else begin
                    grant_n = GNT_NONE;
                end
            end
            ST_BUSY: begin
                // the limit cycle has valid already dropped, so it outranks a late ready
                if (TO_EN && (cnt == CNT_LIMIT)) begin
                    req_valid_n = 1'b0;
                    cnt_n       = CNT_ZERO;
                    terr_n      = 1'b1;
                    resp_fire   = 1'b1;
                    resp_data   = ERR_RDATA;
                    state_n     = ST_RESP;
                end else if (s.mem_ready) begin
                    req_valid_n = 1'b0;
                    cnt_n       = CNT_ZERO;
                    resp_fire   = 1'b1;
                    resp_data   = s.mem_rdata;
                    state_n     = ST_RESP;
                end else begin
                    if (cnt == CNT_SAT) begin
                        cnt_n = cnt;
                    end else begin
                        cnt_n = cnt + CW'(1'b1);
                    end
                    if (TO_EN && (cnt == CNT_PRE)) begin
                        req_valid_n = 1'b0;
                    end else begin
                        req_valid_n = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                last_grant_n = (grant == GNT_M1);
                grant_n      = GNT_NONE;
                cnt_n        = CNT_ZERO;
                state_n      = ST_IDLE;
            end
            default: begin
                state_n     = ST_IDLE;
                grant_n     = GNT_NONE;
                req_valid_n = 1'b0;
                cnt_n       = CNT_ZERO;
            end
        endcase

        if (resp_fire) begin
            if (grant == GNT_M1) begin
                ready_n  = 2'b10;
                rdata1_n = resp_data;
            end else begin
                ready_n  = 2'b01;
                rdata0_n = resp_data;
            end
        end else begin
            ready_n = 2'b00;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            last_grant  <= 1'b1;
            grant       <= GNT_NONE;
            req_valid   <= 1'b0;
            req_addr    <= 32'h0000_0000;
            req_wdata   <= 32'h0000_0000;
            req_wstrb   <= 4'h0;
            ready       <= 2'b00;
            rdata0      <= 32'h0000_0000;
            rdata1      <= 32'h0000_0000;
            timeout_err <= 1'b0;
            cnt         <= CNT_ZERO;
        end else begin
            state       <= state_n;
            last_grant  <= last_grant_n;
            grant       <= grant_n;
            req_valid   <= req_valid_n;
            req_addr    <= req_addr_n;
            req_wdata   <= req_wdata_n;
            req_wstrb   <= req_wstrb_n;
            ready       <= ready_n;
            rdata0      <= rdata0_n;
            rdata1      <= rdata1_n;
            timeout_err <= terr_n;
            cnt         <= cnt_n;
        end
    end

    assign s.mem_valid  = req_valid;
    assign s.mem_addr   = req_addr;
    assign s.mem_wdata  = req_wdata;
    assign s.mem_wstrb  = req_wstrb;
    assign m0.mem_ready = ready[0];
    assign m0.mem_rdata = rdata0;
    assign m1.mem_ready = ready[1];
    assign m1.mem_rdata = rdata1;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: scenario tasks plus a randomized run
// compared against a transaction-level reference model.
module tb_mem_bus_arbiter;
    import mem_bus_pkg::*;

    localparam int TO = 4;

    typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } req_t;
    typedef struct { int cyc; int m; logic [31:0] rdata; logic terr; } evt_t;
    typedef struct { int cyc; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; logic [1:0] gnt; } srec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] grant;
    logic       timeout_err;

    mem_bus_arbiter_if m0_bus ();
    mem_bus_arbiter_if m1_bus ();
    mem_bus_arbiter_if s_bus ();

    mem_bus_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(32'hDEAD_BEEF)) dut (
        .clk         (clk),
        .rst         (rst),
        .m0          (m0_bus),
        .m1          (m1_bus),
        .s           (s_bus),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, s_age = 0, sv_cnt = 0, terr_cnt = 0, viol = 0;
    int lat_override = -1;
    bit slave_never = 1'b0, spurious = 1'b0, fixed_en = 1'b0;
    logic [31:0] fixed_rdata = 32'h0000_0000;
    req_t  mq0[$], mq1[$], ref0[$], ref1[$];
    evt_t  events[$], exp_ev[$];
    srec_t srecs[$], exp_sr[$];

    function automatic int lat_of(input logic [31:0] a);
        if (lat_override >= 0) return lat_override;
        return int'(a[4:2]) % 3;
    endfunction

    function automatic logic [31:0] pattern(input logic [31:0] a);
        if (fixed_en) return fixed_rdata;
        return a ^ 32'hC3C3_0F0F;
    endfunction

    task automatic present(input int m);
        if (m == 0) begin
            if (mq0.size() > 0) begin
                m0_bus.mem_valid = 1'b1; m0_bus.mem_addr = mq0[0].addr;
                m0_bus.mem_wdata = mq0[0].wdata; m0_bus.mem_wstrb = mq0[0].wstrb;
            end else m0_bus.mem_valid = 1'b0;
        end else begin
            if (mq1.size() > 0) begin
                m1_bus.mem_valid = 1'b1; m1_bus.mem_addr = mq1[0].addr;
                m1_bus.mem_wdata = mq1[0].wdata; m1_bus.mem_wstrb = mq1[0].wstrb;
            end else m1_bus.mem_valid = 1'b0;
        end
    endtask

    // One clock: sample outputs after the edge, run master and slave behaviour.
    task automatic tick();
        @(posedge clk); #1;
        cyc++;
        if (s_bus.mem_valid) sv_cnt++;
        if (timeout_err) terr_cnt++;
        if (m0_bus.mem_ready && m1_bus.mem_ready) viol++;
        if (!m0_bus.mem_ready && m0_bus.mem_rdata !== 32'h0) viol++;
        if (!m1_bus.mem_ready && m1_bus.mem_rdata !== 32'h0) viol++;
        if (m0_bus.mem_ready) begin
            events.push_back('{cyc, 0, m0_bus.mem_rdata, timeout_err});
            if (mq0.size() > 0) void'(mq0.pop_front());
        end
        if (m1_bus.mem_ready) begin
            events.push_back('{cyc, 1, m1_bus.mem_rdata, timeout_err});
            if (mq1.size() > 0) void'(mq1.pop_front());
        end
        s_bus.mem_ready = 1'b0;
        s_bus.mem_rdata = $urandom;
        if (s_bus.mem_valid) begin
            if (s_age == 0)
                srecs.push_back('{cyc, s_bus.mem_addr, s_bus.mem_wdata, s_bus.mem_wstrb, grant});
            if (!slave_never && s_age == lat_of(s_bus.mem_addr)) begin
                s_bus.mem_ready = 1'b1;
                s_bus.mem_rdata = pattern(s_bus.mem_addr);
            end
            s_age++;
        end else begin
            s_age = 0;
            s_bus.mem_ready = spurious;
        end
        present(0);
        present(1);
    endtask

    task automatic start_run();
        present(0); present(1);
        if (spurious && !s_bus.mem_valid) s_bus.mem_ready = 1'b1;
        cyc = 0; sv_cnt = 0; terr_cnt = 0;
        events.delete(); srecs.delete();
    endtask

    task automatic run_to_done(input int max, output bit done);
        while ((mq0.size() > 0 || mq1.size() > 0) && cyc < max) tick();
        done = (mq0.size() == 0 && mq1.size() == 0);
        repeat (3) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; mq0.delete(); mq1.delete(); present(0); present(1);
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    // Transaction-level model: sample cycle, winner, and completion cycle per request.
    task automatic ref_model(input int start_last);
        int v0, v1, f, last, c, w, lat, rdy;
        req_t r;
        v0 = 0; v1 = 0; f = 0; last = start_last;
        exp_ev.delete(); exp_sr.delete();
        while (ref0.size() > 0 || ref1.size() > 0) begin
            if (ref0.size() > 0 && ref1.size() > 0) c = (v0 < v1) ? v0 : v1;
            else if (ref0.size() > 0) c = v0;
            else c = v1;
            if (c < f) c = f;
            if (ref0.size() > 0 && ref1.size() > 0 && v0 <= c && v1 <= c) w = 1 - last;
            else if (ref0.size() > 0 && v0 <= c) w = 0;
            else w = 1;
            if (w == 0) r = ref0.pop_front(); else r = ref1.pop_front();
            lat = lat_of(r.addr);
            rdy = c + lat + 2;
            exp_ev.push_back('{rdy, w, pattern(r.addr), 1'b0});
            exp_sr.push_back('{c + 1, r.addr, r.wdata, r.wstrb, (w == 0) ? GNT_M0 : GNT_M1});
            f = rdy + 1;
            if (w == 0) v0 = rdy; else v1 = rdy;
            last = w;
        end
    endtask

    task automatic test_reset();
        logic [137:0] outs;
        rst = 1'b1; tick();
        outs = {grant, timeout_err, s_bus.mem_valid, s_bus.mem_addr, s_bus.mem_wdata, s_bus.mem_wstrb,
                m0_bus.mem_ready, m1_bus.mem_ready, m0_bus.mem_rdata, m1_bus.mem_rdata};
        checks++; if ((|outs) !== 1'b0) begin errors++; $display("FAIL reset_outputs: got %h required all zero", outs); end
        rst = 1'b0; tick(); tick();
        checks++; if (grant !== GNT_NONE || s_bus.mem_valid !== 1'b0) begin errors++;
            $display("FAIL reset_idle: grant %b s_valid %b required 00 0", grant, s_bus.mem_valid); end
    endtask

    task automatic test_single_read();
        bit done;
        lat_override = 1; fixed_en = 1'b1; fixed_rdata = 32'h1234_5678;
        mq0.push_back('{32'h0000_0010, 32'h0000_0000, 4'h0});
        start_run(); run_to_done(40, done);
        checks++; if (!done) begin errors++; $display("FAIL single_done: transaction not completed"); end
        checks++; if (events.size() !== 1) begin errors++; $display("FAIL single_count: got %0d readies required 1", events.size()); end
        if (events.size() > 0) begin
            checks++; if (events[0].cyc !== 3 || events[0].m !== 0) begin errors++;
                $display("FAIL single_timing: got cycle %0d master %0d required cycle 3 master 0", events[0].cyc, events[0].m); end
            checks++; if (events[0].rdata !== 32'h1234_5678) begin errors++;
                $display("FAIL single_rdata: got %h required 12345678", events[0].rdata); end
        end
        checks++; if (srecs.size() !== 1 || srecs[0].cyc !== 1 || srecs[0].addr !== 32'h0000_0010) begin errors++;
            $display("FAIL single_slave_req: got %0d reqs, required one at cycle 1 addr 00000010", srecs.size()); end
        checks++; if (sv_cnt !== 2) begin errors++; $display("FAIL single_svalid_len: got %0d required 2", sv_cnt); end
        lat_override = -1; fixed_en = 1'b0;
    endtask

    task automatic test_simultaneous();
        bit done;
        int          ec[3] = '{2, 5, 8};
        int          em[3] = '{0, 1, 0};
        logic [31:0] ea[3] = '{32'h0000_00A0, 32'h0000_00B0, 32'h0000_00C0};
        do_reset();
        lat_override = 0;
        mq0.push_back('{32'h0000_00A0, 32'hA5A5_A5A5, 4'hF});
        mq0.push_back('{32'h0000_00C0, 32'h0000_0000, 4'h0});
        mq1.push_back('{32'h0000_00B0, 32'h0000_0000, 4'h0});
        start_run(); run_to_done(60, done);
        checks++; if (!done || events.size() !== 3) begin errors++;
            $display("FAIL tie_count: done %0d readies %0d required 1 3", done, events.size()); end
        for (int i = 0; i < 3 && i < events.size(); i++) begin
            checks++; if (events[i].cyc !== ec[i] || events[i].m !== em[i] || events[i].rdata !== pattern(ea[i])) begin
                errors++; $display("FAIL tie_order[%0d]: got cyc %0d m %0d rdata %h required cyc %0d m %0d rdata %h",
                    i, events[i].cyc, events[i].m, events[i].rdata, ec[i], em[i], pattern(ea[i])); end
        end
        if (srecs.size() >= 2) begin
            checks++; if (srecs[0].wdata !== 32'hA5A5_A5A5 || srecs[0].wstrb !== 4'hF || srecs[0].gnt !== GNT_M0) begin errors++;
                $display("FAIL tie_write: got wdata %h wstrb %h gnt %b required a5a5a5a5 f 01", srecs[0].wdata, srecs[0].wstrb, srecs[0].gnt); end
            checks++; if (srecs[1].wstrb !== 4'h0 || srecs[1].gnt !== GNT_M1) begin errors++;
                $display("FAIL tie_read: got wstrb %h gnt %b required 0 10", srecs[1].wstrb, srecs[1].gnt); end
        end
        lat_override = -1;
    endtask

    task automatic test_back_to_back();
        bit done;
        lat_override = 1;
        mq1.push_back('{32'h0000_0100, 32'h0000_0000, 4'h0});
        mq1.push_back('{32'h0000_0204, 32'h0000_0000, 4'h0});
        start_run(); run_to_done(60, done);
        checks++; if (!done || events.size() !== 2) begin errors++;
            $display("FAIL b2b_count: done %0d readies %0d required 1 2", done, events.size()); end
        if (events.size() >= 2 && srecs.size() >= 2) begin
            checks++; if (events[0].cyc !== 3 || events[1].cyc !== 7) begin errors++;
                $display("FAIL b2b_ready_cycles: got %0d %0d required 3 7", events[0].cyc, events[1].cyc); end
            checks++; if (srecs[1].cyc - events[0].cyc !== 2) begin errors++;
                $display("FAIL b2b_idle_gap: got %0d required 2", srecs[1].cyc - events[0].cyc); end
            checks++; if (srecs[1].addr !== 32'h0000_0204) begin errors++;
                $display("FAIL b2b_addr: got %h required 00000204", srecs[1].addr); end
        end
        lat_override = -1;
    endtask

    task automatic test_timeout();
        bit done;
        slave_never = 1'b1;
        mq0.push_back('{32'h0000_0300, 32'h0000_0000, 4'h0});
        start_run(); run_to_done(60, done);
        checks++; if (sv_cnt !== TO) begin errors++; $display("FAIL to_svalid_len: got %0d required %0d", sv_cnt, TO); end
        checks++; if (!done || events.size() !== 1) begin errors++;
            $display("FAIL to_count: done %0d readies %0d required 1 1", done, events.size()); end
        if (events.size() > 0) begin
            checks++; if (events[0].cyc !== TO + 2 || events[0].rdata !== 32'hDEAD_BEEF || events[0].terr !== 1'b1) begin errors++;
                $display("FAIL to_resp: got cyc %0d rdata %h err %b required %0d deadbeef 1",
                    events[0].cyc, events[0].rdata, events[0].terr, TO + 2); end
        end
        checks++; if (terr_cnt !== 1) begin errors++; $display("FAIL to_err_pulse: got %0d cycles required 1", terr_cnt); end
        slave_never = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        bit done;
        logic [137:0] outs;
        slave_never = 1'b1;
        mq1.push_back('{32'h0000_0400, 32'h0000_0000, 4'h0});
        start_run(); tick(); tick();
        checks++; if (grant !== GNT_M1 || s_bus.mem_valid !== 1'b1) begin errors++;
            $display("FAIL rstbusy_pre: grant %b s_valid %b required 10 1", grant, s_bus.mem_valid); end
        rst = 1'b1; mq1.delete(); present(1);
        tick();
        outs = {grant, timeout_err, s_bus.mem_valid, s_bus.mem_addr, s_bus.mem_wdata, s_bus.mem_wstrb,
                m0_bus.mem_ready, m1_bus.mem_ready, m0_bus.mem_rdata, m1_bus.mem_rdata};
        checks++; if ((|outs) !== 1'b0) begin errors++; $display("FAIL rstbusy_outputs: got %h required all zero", outs); end
        rst = 1'b0; slave_never = 1'b0;
        repeat (3) tick();
        checks++; if (events.size() !== 0) begin errors++; $display("FAIL rstbusy_no_ready: got %0d readies required 0", events.size()); end
        lat_override = 0;
        mq0.push_back('{32'h0000_0500, 32'h0000_0000, 4'h0});
        mq1.push_back('{32'h0000_0600, 32'h0000_0000, 4'h0});
        start_run(); run_to_done(60, done);
        checks++; if (!done || events.size() !== 2 || events[0].m !== 0) begin errors++;
            $display("FAIL rstbusy_tie: done %0d readies %0d first master %0d required 1 2 0",
                done, events.size(), (events.size() > 0) ? events[0].m : -1); end
        lat_override = -1;
    endtask

    task automatic test_spurious();
        bit done;
        lat_override = 1; spurious = 1'b1;
        start_run();
        repeat (3) tick();
        checks++; if (events.size() !== 0 || sv_cnt !== 0 || grant !== GNT_NONE) begin errors++;
            $display("FAIL spur_idle: readies %0d s_valid cycles %0d grant %b required 0 0 00", events.size(), sv_cnt, grant); end
        mq0.push_back('{32'h0000_0040, 32'h0000_0000, 4'h0});
        start_run(); run_to_done(40, done);
        checks++; if (!done || events.size() !== 1 || events[0].cyc !== 3 || srecs[0].cyc !== 1) begin errors++;
            $display("FAIL spur_then_req: done %0d readies %0d required one ready at cycle 3", done, events.size()); end
        spurious = 1'b0; lat_override = -1;
    endtask

    task automatic test_random();
        bit done;
        req_t r;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            r.addr  = $urandom & 32'hFFFF_FFFC;
            r.wdata = $urandom;
            r.wstrb = ($urandom_range(1, 0) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
            if ($urandom_range(1, 0) == 0) mq0.push_back(r); else mq1.push_back(r);
        end
        ref0 = mq0; ref1 = mq1;
        ref_model(1);
        start_run(); run_to_done(400, done);
        checks++; if (!done || events.size() !== exp_ev.size() || srecs.size() !== exp_sr.size()) begin errors++;
            $display("FAIL rand_count: done %0d readies %0d/%0d slave reqs %0d/%0d",
                done, events.size(), exp_ev.size(), srecs.size(), exp_sr.size()); end
        for (int i = 0; i < exp_ev.size() && i < events.size(); i++) begin
            checks++; if (events[i].cyc !== exp_ev[i].cyc || events[i].m !== exp_ev[i].m ||
                          events[i].rdata !== exp_ev[i].rdata || events[i].terr !== 1'b0) begin errors++;
                $display("FAIL rand_ready[%0d]: got cyc %0d m %0d rdata %h err %b required cyc %0d m %0d rdata %h err 0",
                    i, events[i].cyc, events[i].m, events[i].rdata, events[i].terr, exp_ev[i].cyc, exp_ev[i].m, exp_ev[i].rdata); end
        end
        for (int i = 0; i < exp_sr.size() && i < srecs.size(); i++) begin
            checks++; if (srecs[i].cyc !== exp_sr[i].cyc || srecs[i].addr !== exp_sr[i].addr || srecs[i].wdata !== exp_sr[i].wdata ||
                          srecs[i].wstrb !== exp_sr[i].wstrb || srecs[i].gnt !== exp_sr[i].gnt) begin errors++;
                $display("FAIL rand_slave[%0d]: got cyc %0d addr %h wdata %h wstrb %h gnt %b required cyc %0d addr %h wdata %h wstrb %h gnt %b",
                    i, srecs[i].cyc, srecs[i].addr, srecs[i].wdata, srecs[i].wstrb, srecs[i].gnt,
                    exp_sr[i].cyc, exp_sr[i].addr, exp_sr[i].wdata, exp_sr[i].wstrb, exp_sr[i].gnt); end
        end
        checks++; if (viol !== 0) begin errors++; $display("FAIL idle_master_outputs: got %0d violations required 0", viol); end
    endtask

    initial begin
        m0_bus.mem_valid = 1'b0; m0_bus.mem_addr = 32'h0; m0_bus.mem_wdata = 32'h0; m0_bus.mem_wstrb = 4'h0;
        m1_bus.mem_valid = 1'b0; m1_bus.mem_addr = 32'h0; m1_bus.mem_wdata = 32'h0; m1_bus.mem_wstrb = 4'h0;
        s_bus.mem_ready = 1'b0; s_bus.mem_rdata = 32'h0;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_back_to_back();
        test_timeout();
        test_reset_mid_busy();
        test_spurious();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master to one-slave arbiter for the PicoRV32 native memory bus. It sits directly upstream of the SRAM wrapper and merges two requesters onto the single slave port: master 0 is the CPU and master 1 is the boot loader / DMA engine. Request capture is registered, arbitration is round-robin, and each grant is held until the slave completes. A per-transaction timeout answers a stalled slave with an error response.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles allowed in BUSY before forced termination; 0 disables the timeout.
- `ERR_RDATA`, default 32'hDEAD_BEEF: read data returned on a timed-out transaction.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `m0_mem_valid` / `m1_mem_valid`  in  1  master request, held until its ready.
- `m0_mem_ready` / `m1_mem_ready`  out  1  one-cycle completion pulse to the master.
- `m0_mem_addr` / `m1_mem_addr`  in  32  byte address.
- `m0_mem_wdata` / `m1_mem_wdata`  in  32  write data.
- `m0_mem_wstrb` / `m1_mem_wstrb`  in  4  byte strobes; 0 = read.
- `m0_mem_rdata` / `m1_mem_rdata`  out  32  read data; valid only with that master's ready.
- `s_mem_valid`  out  1  registered request to the slave.
- `s_mem_ready`  in  1  slave completion.
- `s_mem_addr`, `s_mem_wdata`, `s_mem_wstrb`  out  32/32/4  latched request fields.
- `s_mem_rdata`  in  32  slave read data.
- `grant`  out  2  one-hot owner of the current transaction; 0 in IDLE.
- `timeout_err`  out  1  one-cycle pulse coincident with the errored ready.

## Operation
- FSM has three states: IDLE, BUSY, RESP.
- IDLE: if any `mX_mem_valid` is high, pick a winner, latch its addr/wdata/wstrb into the slave registers, set `grant`, go to BUSY.
- Winner selection:
  - If both masters request, the winner is the master not granted last (`last_grant`).
  - The reset value of `last_grant` is master 1, so master 0 wins the first tie.
- BUSY: `s_mem_valid`=1. When `s_mem_ready` is sampled high, register `s_mem_rdata` and go to RESP; the timeout counter clears.
- BUSY timeout: when the counter reaches `TIMEOUT_CYCLES` (nonzero) without ready:
  - drop `s_mem_valid`;
  - load `ERR_RDATA` into the rdata register;
  - set the error flag and go to RESP.
- RESP:
  - Only the granted master sees ready=1 and rdata for exactly one cycle; `timeout_err` = error flag.
  - `last_grant` updates and the state goes to IDLE. No new grant is issued in RESP.
- Non-granted master: ready=0, rdata=0 at all times.
- Slave inputs are ignored outside BUSY. A spurious `s_mem_ready` in IDLE or RESP has no effect.
- A master dropping valid mid-transaction is a protocol violation. The slave transaction still completes and the ready pulse is still issued.
- Timeout counter: width `$clog2(TIMEOUT_CYCLES+1)`, saturating, counts only in BUSY.

## Timing
- Reset values: all outputs 0, state IDLE, `last_grant`=1, counter 0.
- Reset mid-transaction: at the reset edge `s_mem_valid` drops and the grant is lost. No ready is issued to the master.
- Latency: valid sampled at edge 0 → `s_mem_valid` high in cycle 1. If the slave answers in cycle k, master ready appears in cycle k+1. The minimum is 2 cycles from valid to ready.
- Throughput: one transaction per (slave latency + 2) cycles. The IDLE cycle after RESP is mandatory.
- Simultaneous new request in the RESP cycle: it is sampled in the following IDLE cycle. There is no bypass.
- Timeout: with slave ready never asserted, master ready arrives exactly `TIMEOUT_CYCLES`+2 cycles after valid.

## Structure
- Shared package `mem_bus_pkg`:
  - FSM state encoding (IDLE/BUSY/RESP);
  - `ERR_RDATA` default constant;
  - grant one-hot encodings `GNT_NONE`/`GNT_M0`/`GNT_M1`.
- One sub-module, `rr_arb2`: combinational two-request round-robin pick from (`req[1:0]`, `last_grant`) returning a one-hot grant. The FSM, latches and timeout counter stay in `mem_bus_arbiter`.

## Test plan
- **Single read, m0:**
  - Stimulus: addr 0x0000_0010, slave ready one cycle after `s_mem_valid` with rdata 0x1234_5678.
  - Required: m0 ready pulses exactly once with 0x1234_5678 at cycle 3; m1 ready stays 0.
- **Simultaneous requests:**
  - Stimulus: both masters request after reset, m0 write 0xA5A5_A5A5 strb 4'hF, m1 read.
  - Required: m0 is served first, m1 next. Repeating the tie serves m1 first, confirming alternation.
- **Back-to-back:**
  - Stimulus: m1 re-requests immediately after its ready.
  - Required: one IDLE cycle between transactions, and `s_mem_addr` carries the new address.
- **Timeout:**
  - Stimulus: `TIMEOUT_CYCLES`=4, slave never ready.
  - Required: `s_mem_valid` high for exactly 4 cycles; master ready with 0xDEAD_BEEF and `timeout_err`=1 in the same cycle.
- **Reset mid-BUSY:**
  - Stimulus: `rst` asserted during BUSY.
  - Required: next cycle all outputs are 0 and no ready is issued. After release, a tie goes to m0.
- **Spurious slave ready in IDLE:**
  - Required: no master ready and no state change.
